// File: rtl/add_pkg.sv
// Shared types and default widths for the adder-result accumulator.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } acc_state_t;

  localparam int ADD_DW = 32;
  localparam int ADD_AW = 40;
  localparam int ADD_CW = 8;

endpackage

// File: rtl/acc_add.sv
// Combinational AW-bit add of the running total and one zero-extended input word.
module acc_add
  import add_pkg::*;
#(
  parameter int DW = ADD_DW,
  parameter int AW = ADD_AW
) (
  input  logic [AW-1:0] acc_i,
  input  logic [DW-1:0] data_i,
  output logic [AW-1:0] sum_o,
  output logic          carry_o
);

  logic [AW:0] data_ext;
  logic [AW:0] sum_ext;

  // One extra bit on both operands exposes the carry out of bit AW-1.
  always_comb begin
    data_ext           = '0;
    data_ext[DW-1:0]   = data_i;
    sum_ext            = {1'b0, acc_i} + data_ext;
  end

  assign sum_o   = sum_ext[AW-1:0];
  assign carry_o = sum_ext[AW];

endmodule

// File: rtl/add_accum.sv
// Accumulates a programmed number of adder sums into a wide total and hands the
// result downstream over valid/ready, with a per-run sticky overflow flag.
module add_accum
  import add_pkg::*;
#(
  parameter int DW = ADD_DW,
  parameter int AW = ADD_AW,
  parameter int CW = ADD_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_ovf,
  output logic          busy
);

  acc_state_t    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [AW-1:0] add_sum;
  logic          add_carry;

  acc_add #(
    .DW(DW),
    .AW(AW)
  ) u_acc_add (
    .acc_i  (acc_q),
    .data_i (in_data),
    .sum_o  (add_sum),
    .carry_o(add_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          // An empty run skips ACC and presents a zero total straight away.
          if (len != '0) begin
            cnt_d   = len;
            state_d = ACC;
          end else begin
            state_d = HOLD;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_carry;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on in_valid or out_ready.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add_accum.sv
// Randomized self-checking bench: a 40-bit and a 32-bit accumulator share stimulus
// and are compared against totals computed from the beat list.
module tb_add_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [39:0] out_sum_a;
  logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [31:0] out_sum_b;

  logic [31:0] beats[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_accum #(.DW(32), .AW(40), .CW(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_ovf(out_ovf_a), .busy(busy_a)
  );

  add_accum #(.DW(32), .AW(32), .CW(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_ovf(out_ovf_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_in_ready_a"},  64'(in_ready_a),  0);
    check_eq({tag, "_in_ready_b"},  64'(in_ready_b),  0);
    check_eq({tag, "_out_valid_a"}, 64'(out_valid_a), 0);
    check_eq({tag, "_out_valid_b"}, 64'(out_valid_b), 0);
    check_eq({tag, "_busy_a"},      64'(busy_a),      0);
    check_eq({tag, "_busy_b"},      64'(busy_b),      0);
  endtask

  // Runs one transaction over the beats queue; gap1 idle cycles follow the first
  // beat, bp cycles of backpressure precede the accepting handshake.
  task automatic do_run(input int n, input int gap1, input int bubble_pct,
                        input int bp, input bit poke);
    int idx = 0;
    int guard = 0;
    int gaps = 0;
    bit v;
    longint unsigned total = 0;
    logic [39:0] exp_a;
    logic [31:0] exp_b;
    bit ovf_a, ovf_b;

    for (int i = 0; i < n; i++) total += 64'(beats[i]);
    exp_a = total[39:0];
    exp_b = total[31:0];
    ovf_a = (total >> 40) != 0;
    ovf_b = (total >> 32) != 0;

    start = 1'b1;
    len   = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'($urandom);

    while (idx < n && guard < 2000) begin
      check_eq("acc_in_ready_a",  64'(in_ready_a),  1);
      check_eq("acc_in_ready_b",  64'(in_ready_b),  1);
      check_eq("acc_busy_a",      64'(busy_a),      1);
      check_eq("acc_out_valid_a", 64'(out_valid_a), 0);
      v = ($urandom_range(99) >= 32'(bubble_pct));
      if (idx == 1 && gaps < gap1) begin
        v = 1'b0;
        gaps++;
      end
      in_valid = v;
      in_data  = v ? beats[idx] : $urandom;
      if (poke && idx == 1) begin
        start = 1'b1;
        len   = 8'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (v) idx++;
      guard++;
    end
    if (guard >= 2000) check_eq("acc_timeout", 64'(guard), 0);

    // Junk presented during HOLD must not disturb the held result.
    in_valid  = 1'b1;
    in_data   = $urandom;
    out_ready = 1'b0;
    for (int c = 0; c <= bp; c++) begin
      check_eq("hold_out_valid_a", 64'(out_valid_a), 1);
      check_eq("hold_out_valid_b", 64'(out_valid_b), 1);
      check_eq("hold_in_ready_a",  64'(in_ready_a),  0);
      check_eq("hold_busy_b",      64'(busy_b),      1);
      check_eq("hold_sum_a",       64'(out_sum_a),   64'(exp_a));
      check_eq("hold_ovf_a",       64'(out_ovf_a),   64'(ovf_a));
      check_eq("hold_sum_b",       64'(out_sum_b),   64'(exp_b));
      check_eq("hold_ovf_b",       64'(out_ovf_b),   64'(ovf_b));
      if (c == bp) out_ready = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_idle("post");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check_idle("reset");
    check_eq("reset_sum_a", 64'(out_sum_a), 0);
    check_eq("reset_ovf_b", 64'(out_ovf_b), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_idle("idle");

    beats = '{32'h10, 32'h20, 32'h30};
    do_run(3, 0, 0, 0, 1'b0);

    beats = '{32'hFFFF_FFFF, 32'h1};
    do_run(2, 3, 0, 4, 1'b0);

    beats = '{32'hFFFF_FFFF, 32'h2};
    do_run(2, 0, 0, 1, 1'b0);
    beats = '{32'h5};
    do_run(1, 0, 0, 0, 1'b0);

    beats = '{};
    do_run(0, 0, 0, 2, 1'b0);

    beats = '{32'h1, 32'h2, 32'h3, 32'h4};
    do_run(4, 0, 0, 0, 1'b1);

    // Asynchronous reset in the middle of a run discards the partial total.
    start = 1'b1; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    @(posedge clk); #1;
    in_data = 32'h22;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("midrun_busy_a", 64'(busy_a), 1);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    check_eq("async_rst_sum_a", 64'(out_sum_a), 0);
    check_eq("async_rst_sum_b", 64'(out_sum_b), 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_idle("after_rst");
    beats = '{32'h7};
    do_run(1, 0, 0, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(12);
      beats = '{};
      for (int i = 0; i < n; i++)
        beats.push_back(($urandom_range(2) == 0) ? 32'hFFFF_FFFF : $urandom);
      do_run(n, $urandom_range(2), 30, $urandom_range(3), 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_accum.md
Name: add_accum

Overview:
- Downstream consumer of the 32-bit adder result stream: accumulates a programmed number of `DW`-bit sums into a wide running total.
- Presents the total to the next stage over a valid/ready handshake.
- Provides a sticky overflow flag if the total exceeds `AW` bits.
- Sits between the `add32`-class adder output and any reduction or checksum logic.

Parameters:
- `DW`, 32, width of each incoming sum word
- `AW`, 40, accumulator and result width; must be >= `DW`
- `CW`, 8, width of the beat-count field `len`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous active-high reset
- `start`  in  1  one-cycle pulse that begins a run; sampled only in IDLE
- `len`  in  `CW`  number of input beats in the run; sampled with `start`
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block accepts `in_data` this cycle
- `in_data`  in  `DW`  sum word from the upstream adder
- `out_valid`  out  1  `out_sum` / `out_ovf` valid
- `out_ready`  in  1  downstream accepts the result
- `out_sum`  out  `AW`  accumulated total, modulo 2^`AW`
- `out_ovf`  out  1  sticky: carry out of bit `AW-1` occurred during the run
- `busy`  out  1  high in ACC and HOLD

Behaviour:
- Clocking and reset:
  - One clock, `clk`. Reset is asynchronous and active-high on `rst`.
  - Reset values: state=IDLE, acc=0, cnt=0, ovf=0.
  - Output reset values: `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `busy`=0.
- State machine IDLE / ACC / HOLD. All outputs are registered or decoded from state only; there is no combinational path from `in_valid` or `out_ready` to any output.
- IDLE:
  - `start`=1 and `len`!=0: acc<=0, ovf<=0, cnt<=`len`, go to ACC.
  - `start`=1 and `len`==0: acc<=0, ovf<=0, go to HOLD (empty run yields sum 0 with one cycle latency).
  - `start`=0: stay in IDLE.
- ACC:
  - `in_ready`=1.
  - On each beat (`in_valid`&&`in_ready`): acc <= (acc + zero-extended `in_data`) mod 2^`AW`; ovf <= ovf | carry-out; cnt <= cnt-1.
  - The beat that takes cnt from 1 to 0 moves to HOLD. The result is visible at `out_sum` the cycle after the last beat.
  - `in_valid`=0 is a bubble: no change, no timeout.
- HOLD:
  - `out_valid`=1; `out_sum`=acc and `out_ovf`=ovf, both held stable while `out_ready`=0.
  - `out_valid`&&`out_ready` returns to IDLE. `out_valid` drops the next cycle.
  - `out_ready` asserted the first HOLD cycle gives a one-cycle result pulse.
- `start` in ACC or HOLD is ignored: it neither restarts nor queues a run.
- Outside ACC: `in_ready`=0, and `in_data` is ignored even if `in_valid`=1.
- Width rule: acc is `AW` bits. With the defaults, `len`<=255 beats of 32 bits cannot overflow 40 bits. Overflow is reachable only with a narrower `AW`, and the bench uses `AW`=`DW`=32 to exercise it.
- `rst` asserted mid-run: immediate return to reset values. Any partial sum is discarded and no result is produced.
- `out_sum` outside HOLD shows the current acc value; it is only meaningful while `out_valid`=1.

Decomposition:
- Shared package `add_pkg`:
  - state enum `acc_state_t` {IDLE, ACC, HOLD}
  - default width constants `ADD_DW`=32, `ADD_AW`=40, `ADD_CW`=8
- Sub-module `acc_add`: combinational `AW`-bit add of acc and zero-extended `in_data`, producing sum and carry-out. The FSM, counter and handshake stay in `add_accum`.

Test Plan:
- Basic run: `len`=3; beats 0x10, 0x20, 0x30 with `in_valid` held high; `out_ready`=1 -> `out_valid` one cycle after the third beat; `out_sum`=0x60; `out_ovf`=0; `busy` falls the cycle after.
- Bubbles and backpressure: `len`=2; beats 0xFFFFFFFF, then 3 idle cycles, then 0x1; `out_ready`=0 for 4 cycles -> `out_sum`=0x100000000 held stable with `out_valid`=1 throughout; single handshake on `out_ready`.
- Overflow (`AW`=32): `len`=2; beats 0xFFFFFFFF, 0x2 -> `out_sum`=0x1, `out_ovf`=1. Next run `len`=1, beat 0x5 -> `out_ovf`=0, confirming the flag clears per run.
- Zero length: `start` with `len`=0 -> `in_ready` never rises; `out_valid`=1 the next cycle with `out_sum`=0.
- Ignored `start`: during ACC of a `len`=4 run, pulse `start` with `len`=1 -> run still consumes 4 beats, and exactly one result is produced.
- Reset mid-run: `len`=5; after 2 beats assert `rst` asynchronously between clock edges -> outputs go to reset values immediately. A following run with `len`=1, beat 0x7 gives `out_sum`=0x7.
